// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: word geometry and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int WORD_W      = 16;
  localparam int INSTR_BYTES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {address, instruction} pairs for decode.
// Flush beats push and pop. Head data reads as zero while empty, so the
// storage array itself needs no reset.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     I_clk,
  input  logic                     I_reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             not_empty;
  logic             do_pop;

  assign not_empty = (count != '0);
  assign do_pop    = pop & not_empty;
  assign rd_data   = not_empty ? mem[rd_ptr] : '0;

  // Storage write; callers only push when there is room.
  always_ff @(posedge I_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge I_clk) begin
    if (I_reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues PC-addressed requests to instruction
// memory, steps the PC on each useful accept, buffers fetched words for
// decode and drops stale fetches after a taken branch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic [WIDTH-1:0] I_pc,
  output logic             O_pc_enable,
  input  logic             I_redirect,
  output logic             O_mem_req,
  output logic [WIDTH-1:0] O_mem_addr,
  input  logic             I_mem_ready,
  input  logic [WIDTH-1:0] I_mem_data,
  output logic [WIDTH-1:0] O_instr,
  output logic [WIDTH-1:0] O_instr_pc,
  output logic             O_instr_valid,
  input  logic             I_instr_ready
);

  localparam int               CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_state_e       state;
  logic [WIDTH-1:0]   held_addr;
  logic               mem_req;
  logic               accept;
  logic               pop;
  logic               push;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_post;
  logic               room;
  logic [2*WIDTH-1:0] head;

  assign accept = mem_req & I_mem_ready;
  assign pop    = O_instr_valid & I_instr_ready;
  // A word is kept only when it belongs to the current, non-redirected stream.
  assign push   = accept & (state == ST_BUSY) & ~I_redirect;

  // On redirect the PC block's write wins, so enabling it loads the target.
  assign O_pc_enable = ~I_reset & ((accept & (state == ST_BUSY) & ~I_redirect) | I_redirect);

  assign O_mem_req     = mem_req;
  assign O_mem_addr    = (state == ST_DROP) ? held_addr : I_pc;
  assign O_instr_valid = (count != '0);
  assign O_instr       = head[WIDTH-1:0];
  assign O_instr_pc    = head[2*WIDTH-1:WIDTH];

  fetch_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .I_clk   (I_clk),
    .I_reset (I_reset),
    .push    (push),
    .pop     (pop),
    .flush   (I_redirect),
    .wr_data ({I_pc, I_mem_data}),
    .rd_data (head),
    .count   (count)
  );

  // Occupancy the buffer will have after this edge; decides whether to keep fetching.
  always_comb begin
    count_post = count;
    if (I_redirect) begin
      count_post = '0;
    end else if (push && !pop) begin
      count_post = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_post = count - CNT_W'(1);
    end
  end

  assign room = (count_post < FULL_CNT);

  // Remember the address still outstanding when a branch overtakes it.
  always_ff @(posedge I_clk) begin
    if ((state == ST_BUSY) && I_redirect && !accept) begin
      held_addr <= I_pc;
    end
  end

  // Fetch FSM; the request is registered and only falls after a completed accept.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state   <= ST_IDLE;
      mem_req <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (room) begin
            state   <= ST_BUSY;
            mem_req <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (I_redirect) begin
            if (!accept) begin
              state <= ST_DROP;
            end
          end else if (accept && !room) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
          end
        end
        ST_DROP: begin
          if (accept) begin
            if (room) begin
              state <= ST_BUSY;
            end else begin
              state   <= ST_IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural PC block and a memory
// that returns the request address as instruction data.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        I_clk = 1'b0;
  logic        I_reset;
  logic [15:0] I_pc;
  logic        O_pc_enable;
  logic        I_redirect;
  logic        O_mem_req;
  logic [15:0] O_mem_addr;
  logic        I_mem_ready;
  logic [15:0] I_mem_data;
  logic [15:0] O_instr;
  logic [15:0] O_instr_pc;
  logic        O_instr_valid;
  logic        I_instr_ready;

  logic [15:0] target;
  int          n_checks = 0;
  int          n_errors = 0;
  int          pulses;

  fetch_unit #(.WIDTH(16), .DEPTH(2)) dut (
    .I_clk         (I_clk),
    .I_reset       (I_reset),
    .I_pc          (I_pc),
    .O_pc_enable   (O_pc_enable),
    .I_redirect    (I_redirect),
    .O_mem_req     (O_mem_req),
    .O_mem_addr    (O_mem_addr),
    .I_mem_ready   (I_mem_ready),
    .I_mem_data    (I_mem_data),
    .O_instr       (O_instr),
    .O_instr_pc    (O_instr_pc),
    .O_instr_valid (O_instr_valid),
    .I_instr_ready (I_instr_ready)
  );

  always #5 I_clk = ~I_clk;

  assign I_mem_data = O_mem_addr;

  // PC block: write beats increment.
  always @(posedge I_clk) begin
    if (I_reset) I_pc <= 16'h0000;
    else if (O_pc_enable) I_pc <= I_redirect ? target : I_pc + 16'(INSTR_BYTES);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  initial begin
    I_reset = 1'b1; I_redirect = 1'b0; target = 16'h0000;
    I_mem_ready = 1'b1; I_instr_ready = 1'b1;
    tick(); tick();
    #1;
    chk("rst_req",   O_mem_req, 0);
    chk("rst_valid", O_instr_valid, 0);
    chk("rst_pcen",  O_pc_enable, 0);
    chk("rst_instr", O_instr, 0);
    chk("rst_ipc",   O_instr_pc, 0);
    I_reset = 1'b0;
    #1 chk("c0_req", O_mem_req, 0);

    // zero-wait streaming
    tick(); #1;
    chk("c1_req", O_mem_req, 1); chk("c1_addr", O_mem_addr, 16'h0000);
    chk("c1_pcen", O_pc_enable, 1); chk("c1_valid", O_instr_valid, 0);
    tick(); #1;
    chk("c2_addr", O_mem_addr, 16'h0002); chk("c2_valid", O_instr_valid, 1);
    chk("c2_ipc", O_instr_pc, 16'h0000); chk("c2_instr", O_instr, 16'h0000);

    // three wait states on 0x0004
    tick(); I_mem_ready = 1'b0; #1;
    pulses = 0;
    chk("c3_addr", O_mem_addr, 16'h0004); chk("c3_ipc", O_instr_pc, 16'h0002);
    chk("c3_instr", O_instr, 16'h0002);
    pulses += int'(O_pc_enable);
    tick(); #1;
    chk("c4_addr", O_mem_addr, 16'h0004); chk("c4_valid", O_instr_valid, 0);
    pulses += int'(O_pc_enable);
    tick(); #1;
    chk("c5_addr", O_mem_addr, 16'h0004);
    pulses += int'(O_pc_enable);
    tick(); I_mem_ready = 1'b1; #1;
    chk("c6_addr", O_mem_addr, 16'h0004); chk("c6_pcen", O_pc_enable, 1);
    pulses += int'(O_pc_enable);
    chk("wait_pulses", pulses, 1);

    // redirect to 0x0100 while waiting on 0x0006
    tick(); I_mem_ready = 1'b0; #1;
    chk("c7_addr", O_mem_addr, 16'h0006); chk("c7_ipc", O_instr_pc, 16'h0004);
    tick(); I_redirect = 1'b1; target = 16'h0100; #1;
    chk("c8_pcen", O_pc_enable, 1); chk("c8_addr", O_mem_addr, 16'h0006);
    tick(); I_redirect = 1'b0; #1;
    chk("c9_addr", O_mem_addr, 16'h0006); chk("c9_req", O_mem_req, 1);
    chk("c9_pcen", O_pc_enable, 0); chk("c9_valid", O_instr_valid, 0);
    tick(); I_mem_ready = 1'b1; #1;
    chk("c10_addr", O_mem_addr, 16'h0006); chk("c10_pcen", O_pc_enable, 0);
    tick(); #1;
    chk("c11_addr", O_mem_addr, 16'h0100); chk("c11_valid", O_instr_valid, 0);
    chk("c11_pcen", O_pc_enable, 1);
    tick(); #1;
    chk("c12_ipc", O_instr_pc, 16'h0100); chk("c12_instr", O_instr, 16'h0100);
    chk("c12_addr", O_mem_addr, 16'h0102);

    // redirect coincident with accept and pop
    I_redirect = 1'b1; target = 16'h0100; #1;
    chk("c12_pcen", O_pc_enable, 1);
    tick(); I_redirect = 1'b0; I_mem_ready = 1'b0; #1;
    chk("c13_valid", O_instr_valid, 0); chk("c13_pcen", O_pc_enable, 0);
    chk("c13_addr", O_mem_addr, 16'h0100);

    // decode stalled: fill the buffer
    tick(); I_mem_ready = 1'b1; I_instr_ready = 1'b0; #1;
    chk("c14_addr", O_mem_addr, 16'h0100);
    tick(); #1;
    chk("c15_addr", O_mem_addr, 16'h0102);
    tick(); #1;
    chk("c16_req", O_mem_req, 0); chk("c16_pcen", O_pc_enable, 0);
    chk("c16_ipc", O_instr_pc, 16'h0100);
    tick(); #1;
    chk("c17_req", O_mem_req, 0);
    I_instr_ready = 1'b1;
    tick(); I_instr_ready = 1'b0; I_mem_ready = 1'b0; #1;
    chk("c18_req", O_mem_req, 1); chk("c18_addr", O_mem_addr, 16'h0104);
    chk("c18_ipc", O_instr_pc, 16'h0102);

    // reset during a wait state
    tick(); I_reset = 1'b1; #1;
    chk("c19_pcen", O_pc_enable, 0);
    tick(); I_reset = 1'b0; I_mem_ready = 1'b1; I_instr_ready = 1'b1; #1;
    chk("c20_req", O_mem_req, 0); chk("c20_valid", O_instr_valid, 0);
    chk("c20_pcen", O_pc_enable, 0); chk("c20_instr", O_instr, 0);
    tick(); #1;
    chk("c21_req", O_mem_req, 1); chk("c21_addr", O_mem_addr, 16'h0000);

    // address wrap through the PC
    I_redirect = 1'b1; target = 16'hFFFE;
    tick(); I_redirect = 1'b0; #1;
    chk("c22_addr", O_mem_addr, 16'hFFFE); chk("c22_valid", O_instr_valid, 0);
    tick(); #1;
    chk("c23_addr", O_mem_addr, 16'h0000); chk("c23_ipc", O_instr_pc, 16'hFFFE);
    chk("c23_instr", O_instr, 16'hFFFE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
